// File: rtl/pipeline_skid_stage.sv
// pipeline_skid_stage
//   Elastic pipeline stage with a two-entry skid buffer. The payload moves
//   forward with valid, and ready is applied backward. in_ready is registered,
//   so there is no combinational path from out_ready to in_ready, and a word
//   can still pass on every edge.
//   All state updates on the falling edge of clk. reset is synchronous and
//   active-low. flush discards held data synchronously.
//   Optional feature: define PIPE_STAGE_STATS_EN to build the saturating
//   downstream-stall counter. Without it, stall_count is driven to 0.
module pipeline_skid_stage #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [N-1:0]   main_r;
    logic [N-1:0]   main_next_s;
    logic [N-1:0]   skid_r;
    logic [N-1:0]   skid_next_s;
    logic           in_ready_r;
    logic           in_ready_next_s;
    logic           out_valid_r;
    logic           out_valid_next_s;
    logic           in_xfer_s;
    logic           out_xfer_s;

    assign in_xfer_s  = in_valid & in_ready_r;
    assign out_xfer_s = out_valid_r & out_ready;

    // State, payload registers and registered handshake outputs
    always_ff @(negedge clk) begin
        if (!reset) begin
            state_r     <= ST_EMPTY;
            main_r      <= {N{1'b0}};
            skid_r      <= {N{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            main_r      <= main_next_s;
            skid_r      <= skid_next_s;
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= out_valid_next_s;
        end
    end

    // Next state and payload movement; flush empties everything and
    // drops any input transfer happening on the same edge
    always_comb begin
        state_next_s = state_r;
        main_next_s  = main_r;
        skid_next_s  = skid_r;
        if (flush) begin
            state_next_s = ST_EMPTY;
            main_next_s  = {N{1'b0}};
            skid_next_s  = {N{1'b0}};
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_next_s = ST_BUSY;
                        main_next_s  = in_data;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer_s && out_ready) begin
                        state_next_s = ST_BUSY;
                        main_next_s  = in_data;
                    end else if (in_xfer_s) begin
                        // downstream stalled: park the new word in the skid slot
                        state_next_s = ST_FULL;
                        skid_next_s  = in_data;
                    end else if (out_ready) begin
                        // main keeps its last value so out_data does not glitch
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_next_s = ST_BUSY;
                        main_next_s  = skid_r;
                    end else begin
                        state_next_s = ST_FULL;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                    main_next_s  = {N{1'b0}};
                    skid_next_s  = {N{1'b0}};
                end
            endcase
        end
    end

    // Values of the registered handshake outputs for the coming edge
    always_comb begin
        in_ready_next_s  = 1'b0;
        out_valid_next_s = 1'b0;
        if (state_next_s != ST_FULL && !flush) begin
            in_ready_next_s = 1'b1;
        end else begin
            in_ready_next_s = 1'b0;
        end
        if (state_next_s != ST_EMPTY) begin
            out_valid_next_s = 1'b1;
        end else begin
            out_valid_next_s = 1'b0;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_count_r;

    // Saturating count of edges where a valid word was held back by downstream
    always_ff @(negedge clk) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && !out_ready && stall_count_r != CNT_MAX) begin
            stall_count_r <= stall_count_r + CNT_ONE;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`else
    assign stall_count = {CNT_W{1'b0}};
`endif

endmodule
